// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the raster timing generator and the colour logic / VGA pins.
// The timing generator is the master: it issues scan coordinates and drives the pins.
interface vga_timing_gen_if;
  logic        pix_en;
  logic [10:0] draw_x;
  logic [9:0]  draw_y;
  logic [3:0]  draw_r;
  logic [3:0]  draw_g;
  logic [3:0]  draw_b;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        frame_tick;

  modport master (
    input  pix_en, draw_r, draw_g, draw_b,
    output draw_x, draw_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick
  );

  modport slave (
    output pix_en, draw_r, draw_g, draw_b,
    input  draw_x, draw_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/blank delay line matched to the colour pipeline, and the
// registered VGA pin stage with blanking; also emits a start-of-vblank frame tick.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 64,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 200,
  parameter int V_ACTIVE = 800,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 24,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b1,
  parameter int PIPE     = 2
) (
  input logic clk,
  input logic rst_n,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_PRE_BL = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 1024 || PIPE < 1 || PIPE > 4) begin : g_bad_params
      $error("vga_timing_gen: totals exceed 11/10-bit counters or PIPE outside 1..4");
    end
  endgenerate

  logic [10:0] hcount_p0;
  logic [9:0]  vcount_p0;
  logic        tick_p0;
  logic        h_last, v_last;
  logic        active_raw, hs_raw, vs_raw;

  logic [PIPE-1:0] act_dly_p1;
  logic [PIPE-1:0] hs_dly_p1;
  logic [PIPE-1:0] vs_dly_p1;

  logic [3:0] r_p2, g_p2, b_p2;
  logic       hs_p2, vs_p2;

  // Stage 0: scan counters and frame tick
  assign h_last = (hcount_p0 == H_LAST);
  assign v_last = (vcount_p0 == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_p0 <= '0;
      vcount_p0 <= '0;
      tick_p0   <= 1'b0;
    end else begin
      // Pulses for one clk only; cleared on any following cycle, enabled or not.
      tick_p0 <= bus.pix_en && h_last && (vcount_p0 == V_PRE_BL);
      if (bus.pix_en) begin
        if (h_last) begin
          hcount_p0 <= '0;
          vcount_p0 <= v_last ? '0 : vcount_p0 + 10'd1;
        end else begin
          hcount_p0 <= hcount_p0 + 11'd1;
        end
      end
    end
  end

  assign active_raw = (hcount_p0 < H_ACT) && (vcount_p0 < V_ACT);
  assign hs_raw     = (hcount_p0 >= HS_FIRST && hcount_p0 <= HS_LAST) ? H_POL : ~H_POL;
  assign vs_raw     = (vcount_p0 >= VS_FIRST && vcount_p0 <= VS_LAST) ? V_POL : ~V_POL;

  // Stage 1: delay line matching the external colour pipeline depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_dly_p1 <= '0;
      hs_dly_p1  <= {PIPE{~H_POL}};
      vs_dly_p1  <= {PIPE{~V_POL}};
    end else if (bus.pix_en) begin
      act_dly_p1[0] <= active_raw;
      hs_dly_p1[0]  <= hs_raw;
      vs_dly_p1[0]  <= vs_raw;
      for (int i = 1; i < PIPE; i++) begin
        act_dly_p1[i] <= act_dly_p1[i-1];
        hs_dly_p1[i]  <= hs_dly_p1[i-1];
        vs_dly_p1[i]  <= vs_dly_p1[i-1];
      end
    end
  end

  // Stage 2: registered pins with blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p2  <= '0;
      g_p2  <= '0;
      b_p2  <= '0;
      hs_p2 <= ~H_POL;
      vs_p2 <= ~V_POL;
    end else if (bus.pix_en) begin
      hs_p2 <= hs_dly_p1[PIPE-1];
      vs_p2 <= vs_dly_p1[PIPE-1];
      if (act_dly_p1[PIPE-1]) begin
        r_p2 <= bus.draw_r;
        g_p2 <= bus.draw_g;
        b_p2 <= bus.draw_b;
      end else begin
        r_p2 <= '0;
        g_p2 <= '0;
        b_p2 <= '0;
      end
    end
  end

  assign bus.draw_x     = hcount_p0;
  assign bus.draw_y     = vcount_p0;
  assign bus.frame_tick = tick_p0;
  assign bus.vga_r      = r_p2;
  assign bus.vga_g      = g_p2;
  assign bus.vga_b      = b_p2;
  assign bus.vga_hs     = hs_p2;
  assign bus.vga_vs     = vs_p2;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster, compared each cycle against a model
// that derives every coordinate and pin value from the number of enabled cycles.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 4;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;
  localparam int PIPE = 2;
  localparam bit H_POL = 1'b0;
  localparam bit V_POL = 1'b1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pins_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   n = 0;
  bit   last_en = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if bus();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_POL(H_POL), .V_POL(V_POL), .PIPE(PIPE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Coordinate after k enabled cycles since reset release.
  function automatic int cx(int k);
    return k % HT;
  endfunction

  function automatic int cy(int k);
    return (k / HT) % VT;
  endfunction

  // Pins after k enabled cycles: the coordinate issued PIPE+1 enabled cycles earlier.
  function automatic pins_t exp_pins(int k);
    pins_t p;
    int m, x, y;
    p.hs = !H_POL;
    p.vs = !V_POL;
    p.r = 4'd0;
    p.g = 4'd0;
    p.b = 4'd0;
    if (k >= PIPE + 1) begin
      m = k - 1 - PIPE;
      x = cx(m);
      y = cy(m);
      p.hs = (x >= HA + HFP && x < HA + HFP + HSW) ? H_POL : !H_POL;
      p.vs = (y >= VA + VFP && y < VA + VFP + VSW) ? V_POL : !V_POL;
      if (x < HA && y < VA) begin
        p.r = 4'(x);
        p.g = 4'(y);
        p.b = 4'hF;
      end
    end
    return p;
  endfunction

  function automatic bit exp_tick(int k, bit en);
    return en && (k > 0) && (cx(k) == 0) && (cy(k) == VA);
  endfunction

  function automatic pins_t got_pins();
    return {bus.vga_hs, bus.vga_vs, bus.vga_r, bus.vga_g, bus.vga_b};
  endfunction

  // One clk: drive colour for the current coordinate pipeline, advance the model.
  task automatic tick(bit en);
    int m;
    bus.pix_en = en;
    if (n >= PIPE) begin
      m = n - PIPE;
      bus.draw_r = 4'(cx(m));
      bus.draw_g = 4'(cy(m));
      bus.draw_b = 4'hF;
    end else begin
      {bus.draw_r, bus.draw_g, bus.draw_b} = 12'($urandom);
    end
    @(posedge clk);
    last_en = en && (rst_n === 1'b1);
    if (last_en) n++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pix_en = 1'b1;
    {bus.draw_r, bus.draw_g, bus.draw_b} = 12'hFFF;
    repeat (3) @(negedge clk);
    tests++; if (bus.draw_x !== 11'd0) begin fails++; $display("FAIL reset_draw_x got %0d exp 0", bus.draw_x); end
    tests++; if (bus.draw_y !== 10'd0) begin fails++; $display("FAIL reset_draw_y got %0d exp 0", bus.draw_y); end
    tests++; if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h000) begin fails++; $display("FAIL reset_rgb got %h exp 000", {bus.vga_r, bus.vga_g, bus.vga_b}); end
    tests++; if (bus.vga_hs !== !H_POL) begin fails++; $display("FAIL reset_hs got %b exp %b", bus.vga_hs, !H_POL); end
    tests++; if (bus.vga_vs !== !V_POL) begin fails++; $display("FAIL reset_vs got %b exp %b", bus.vga_vs, !V_POL); end
    tests++; if (bus.frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b exp 0", bus.frame_tick); end
    rst_n = 1'b1;
    n = 0;
    last_en = 1'b0;
  endtask

  task automatic test_line_frame();
    int hs_cnt, vs_cnt, tk_cnt;
    pins_t e;
    for (int i = 0; i < FR + PIPE + 1; i++) begin
      tick(1'b1);
      e = exp_pins(n);
      tests++;
      if (got_pins() !== e || bus.draw_x !== 11'(cx(n)) || bus.draw_y !== 10'(cy(n)) ||
          bus.frame_tick !== exp_tick(n, last_en)) begin
        fails++;
        if (fails <= 20) $display("FAIL line_frame n=%0d got x=%0d y=%0d pins=%h tick=%b exp x=%0d y=%0d pins=%h tick=%b",
          n, bus.draw_x, bus.draw_y, got_pins(), bus.frame_tick, cx(n), cy(n), e, exp_tick(n, last_en));
      end
    end
    hs_cnt = 0; vs_cnt = 0; tk_cnt = 0;
    for (int i = 0; i < FR; i++) begin
      tick(1'b1);
      if (bus.vga_hs == H_POL) hs_cnt++;
      if (bus.vga_vs == V_POL) vs_cnt++;
      if (bus.frame_tick) tk_cnt++;
    end
    tests++; if (hs_cnt != HSW * VT) begin fails++; $display("FAIL hs_active_per_frame got %0d exp %0d", hs_cnt, HSW * VT); end
    tests++; if (vs_cnt != VSW * HT) begin fails++; $display("FAIL vs_active_per_frame got %0d exp %0d", vs_cnt, VSW * HT); end
    tests++; if (tk_cnt != 1) begin fails++; $display("FAIL ticks_per_frame got %0d exp 1", tk_cnt); end
  endtask

  task automatic test_clock_enable();
    pins_t e;
    bit en;
    for (int i = 0; i < 6 * FR; i++) begin
      en = (i < 4 * FR) ? (i % 4 == 3) : ($urandom_range(0, 2) == 0);
      tick(en);
      e = exp_pins(n);
      tests++;
      if (got_pins() !== e || bus.draw_x !== 11'(cx(n)) || bus.draw_y !== 10'(cy(n)) ||
          bus.frame_tick !== exp_tick(n, last_en)) begin
        fails++;
        if (fails <= 20) $display("FAIL clock_enable n=%0d en=%b got x=%0d y=%0d pins=%h tick=%b exp x=%0d y=%0d pins=%h tick=%b",
          n, en, bus.draw_x, bus.draw_y, got_pins(), bus.frame_tick, cx(n), cy(n), e, exp_tick(n, last_en));
      end
    end
  endtask

  task automatic test_reset_mid();
    pins_t e;
    int steps;
    for (int rep = 0; rep < 2; rep++) begin
      steps = $urandom_range(HT, FR - 1);
      repeat (steps) tick(1'b1);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (bus.draw_x !== 11'd0 || bus.draw_y !== 10'd0 || got_pins() !== exp_pins(0) || bus.frame_tick !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_immediate got x=%0d y=%0d pins=%h tick=%b exp x=0 y=0 pins=%h tick=0",
          bus.draw_x, bus.draw_y, got_pins(), bus.frame_tick, exp_pins(0));
      end
      n = 0;
      repeat (3) tick(1'b1);
      tests++;
      if (bus.draw_x !== 11'd0 || bus.draw_y !== 10'd0 || got_pins() !== exp_pins(0)) begin
        fails++;
        $display("FAIL reset_mid_hold got x=%0d y=%0d pins=%h exp x=0 y=0 pins=%h",
          bus.draw_x, bus.draw_y, got_pins(), exp_pins(0));
      end
      rst_n = 1'b1;
      n = 0;
      last_en = 1'b0;
      for (int i = 0; i < FR + PIPE + 2; i++) begin
        tick((rep == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        e = exp_pins(n);
        tests++;
        if (got_pins() !== e || bus.draw_x !== 11'(cx(n)) || bus.draw_y !== 10'(cy(n)) ||
            bus.frame_tick !== exp_tick(n, last_en)) begin
          fails++;
          if (fails <= 20) $display("FAIL reset_mid_restart n=%0d got x=%0d y=%0d pins=%h tick=%b exp x=%0d y=%0d pins=%h tick=%b",
            n, bus.draw_x, bus.draw_y, got_pins(), bus.frame_tick, cx(n), cy(n), e, exp_tick(n, last_en));
        end
      end
    end
  endtask

  task automatic test_wrap();
    pins_t e;
    int budget;
    budget = 0;
    while (!(cx(n) == HT - 1 && cy(n) == VT - 1) && budget < 2 * FR) begin
      tick(1'b1);
      budget++;
    end
    tests++;
    if (bus.draw_x !== 11'(HT - 1) || bus.draw_y !== 10'(VT - 1)) begin
      fails++;
      $display("FAIL wrap_reach got x=%0d y=%0d exp x=%0d y=%0d", bus.draw_x, bus.draw_y, HT - 1, VT - 1);
    end
    tick(1'b1);
    tests++;
    if (bus.draw_x !== 11'd0 || bus.draw_y !== 10'd0 || bus.frame_tick !== 1'b0 || bus.vga_vs !== !V_POL) begin
      fails++;
      $display("FAIL wrap_step got x=%0d y=%0d tick=%b vs=%b exp x=0 y=0 tick=0 vs=%b",
        bus.draw_x, bus.draw_y, bus.frame_tick, bus.vga_vs, !V_POL);
    end
    for (int i = 0; i < 3 * FR; i++) begin
      tick(1'($urandom_range(0, 3) != 0));
      e = exp_pins(n);
      tests++;
      if (bus.draw_x >= 11'(HT) || bus.draw_y >= 10'(VT) || got_pins() !== e ||
          bus.draw_x !== 11'(cx(n)) || bus.draw_y !== 10'(cy(n)) || bus.frame_tick !== exp_tick(n, last_en)) begin
        fails++;
        if (fails <= 20) $display("FAIL wrap_run n=%0d got x=%0d y=%0d pins=%h tick=%b exp x=%0d y=%0d pins=%h tick=%b",
          n, bus.draw_x, bus.draw_y, got_pins(), bus.frame_tick, cx(n), cy(n), e, exp_tick(n, last_en));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pix_en = 1'b0;
    bus.draw_r = 4'd0;
    bus.draw_g = 4'd0;
    bus.draw_b = 4'd0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_line_frame();
    test_clock_enable();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator and pixel output stage for the GoldMiner VGA path. It owns the horizontal and vertical counters, which become the `draw_x`/`draw_y` scan coordinates consumed by the pixel colour logic and its sprite ROMs. It accepts the resulting 4-bit RGB back, delays sync and blank to match the colour pipeline, and drives the VGA connector pins with blanking applied. It also emits a once-per-frame tick that the game logic uses to update object positions during vertical blanking.

## Interface
Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 64, horizontal front porch
- H_SYNC, 136, hsync width
- H_BP, 200, horizontal back porch (line total 1680)
- V_ACTIVE, 800, visible lines
- V_FP, 1, vertical front porch
- V_SYNC, 3, vsync width
- V_BP, 24, vertical back porch (frame total 828)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 1, vsync active level
- PIPE, 2, cycles from a `draw_x`/`draw_y` change to valid `draw_r/g/b`; legal range 1–4

Ports:
- clk  in  1  pixel-domain clock; one clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel clock enable; all state advances only when high
- draw_r, draw_g, draw_b  in  4 each  colour for the coordinate issued PIPE enabled cycles earlier
- draw_x  out  11  horizontal counter, 0..1679
- draw_y  out  10  vertical counter, 0..827
- vga_r, vga_g, vga_b  out  4 each  registered pixel colour, forced to 0 in blanking
- vga_hs, vga_vs  out  1 each  registered sync pins
- frame_tick  out  1  one-cycle pulse at the start of vertical blanking

## Operation
- hcount and vcount are registers, output directly as `draw_x` and `draw_y`.
- On an enabled cycle, hcount increments. At H_TOTAL-1 (1679) it wraps to 0 and vcount increments. vcount wraps from V_TOTAL-1 (827) to 0.
- active = (hcount < H_ACTIVE) & (vcount < V_ACTIVE).
- hs_raw = H_POL when hcount is in [1344, 1479], else ~H_POL.
- vs_raw = V_POL when vcount is in [801, 803], else ~V_POL. vs_raw is evaluated on the whole line, with no half-line offset.
- {active, hs_raw, vs_raw} pass through a PIPE-deep shift register, clocked on pix_en.
- The final output register samples the delayed signals on an enabled cycle:
  - vga_hs and vga_vs take the last stage of the delay.
  - vga_r/g/b take draw_r/g/b when the delayed active is 1, else 0.
- frame_tick is 1 for exactly one clk cycle, on the enabled cycle in which the counters move to (0, V_ACTIVE). It is not delayed by PIPE.
- draw_x/draw_y keep counting through blanking. Downstream logic must not rely on them being below H_ACTIVE/V_ACTIVE.
- Counter widths are fixed at 11/10 bits. Parameter sets whose totals exceed 2048/1024 are illegal; an elaboration-time check fires on them.

## Timing
- Reset (asynchronous assert, synchronous release):
  - draw_x = 0, draw_y = 0, vga_r/g/b = 0, frame_tick = 0.
  - vga_hs = ~H_POL, vga_vs = ~V_POL.
  - All delay stages are loaded with active = 0 and inactive sync levels.
- Latency: the coordinate (x, y) presented on draw_x/draw_y appears on the vga_* pins PIPE+1 enabled cycles later.
- Sync and colour stay mutually aligned at every PIPE value.
- pix_en low: every register holds, including the outputs and the delay line, and frame_tick stays 0. An enabled cycle after any stall length resumes exactly where it left off.
- Simultaneous wraps: at (1679, 827) an enabled cycle gives (0, 0) in one step, with no frame_tick.
- Reset mid-frame: everything returns immediately to the reset values above. The first enabled cycle after release shows draw_x = 1, draw_y = 0. Stale colour never reaches the pins, because the delay line is reset to blank.

## Test plan
- Line timing (pix_en tied 1, defaults): measure vga_hs. Required: low for 136 clk, period 1680 clk. Its first fall comes PIPE+1 cycles after draw_x = 1344.
- Frame timing: required vga_vs high for exactly 3×1680 clk, period 1,391,040 clk, and frame_tick once per frame when draw_y becomes 800 with draw_x = 0.
- Blanking/alignment with PIPE = 2: drive draw_r/g/b = {draw_x[3:0], draw_y[3:0], 4'hF} delayed by 2 cycles. Required:
  - every pixel in the active region shows the matching pattern;
  - all pins are 0 at x ≥ 1280 or y ≥ 800;
  - the first visible pixel of a line is x = 0.
- Clock enable: pix_en = 1 on every 4th cycle. Required: identical output sequence stretched ×4, frame_tick exactly one clk wide, and no counter change on disabled cycles.
- Reset mid-frame: assert rst_n low at (700, 400) for 3 cycles, asynchronously to clk. Required:
  - outputs are at reset values within the same cycle;
  - after release, a clean frame restarts from (0, 0);
  - no nonzero RGB for PIPE+1 cycles.
- Wrap corner: run through (1679, 827). Required: the next value is (0, 0), vga_vs is inactive at the frame boundary, and both draw_x and draw_y stay below 1680 and 828 over 3 frames.
